// File: rtl/spi_ctrl_pkg.sv
// Shared types and default parameter values for the SPI capture controller.
// Contents:
//   DEF_*    default values for CLK_DIV, FRAME_BITS, DATA_BITS, SAMPLE_PERIOD
//   state_e  frame sequencer states
package spi_ctrl_pkg;

  localparam int unsigned DEF_CLK_DIV       = 4;
  localparam int unsigned DEF_FRAME_BITS    = 34;
  localparam int unsigned DEF_DATA_BITS     = 16;
  localparam int unsigned DEF_SAMPLE_PERIOD = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_FINISH,
    ST_PUBLISH
  } state_e;

endpackage

// File: rtl/spi_sclk_div.sv
// Serial clock divider: half-period tick generator and sclk toggle.
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   run_i       high: divider counts; low: counter cleared, sclk low
//   hold_low_i  high: counter keeps running but sclk is held low, no strobes
//   sclk_o      registered serial clock
//   tick_o      last cycle of the current half period
//   rise_o      sclk goes 0->1 on the coming clock edge
//   fall_o      sclk goes 1->0 on the coming clock edge
module spi_sclk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic hold_low_i,
  output logic sclk_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;

  assign tick_o = run_i && (cnt_q == CNT_MAX);
  assign rise_o = tick_o && !hold_low_i && !sclk_q;
  assign fall_o = tick_o && !hold_low_i &&  sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
      if (hold_low_i) begin
        sclk_q <= 1'b0;
      end else if (tick_o) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/spi_capture_ctrl.sv
// Periodic SPI frame capture controller. Every SAMPLE_PERIOD clocks (while
// enabled) it runs one chip-select frame of FRAME_BITS sclk pulses, captures
// the leading DATA_BITS of miso MSB first and publishes them through a
// valid/ready register; samples that cannot be delivered set a sticky overrun.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   enable                run periodic captures
//   miso                  serial data from converter
//   sclk, cs              serial clock (idle low), chip select (active low)
//   sample_data/valid     captured sample and its valid flag
//   sample_ready          consumer handshake
//   clr_overrun, overrun  sticky dropped-sample flag and its clear
//   busy                  sequencer not idle
module spi_capture_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DEF_CLK_DIV,
  parameter int unsigned FRAME_BITS    = DEF_FRAME_BITS,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  input  logic                 clr_overrun,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);

  state_e                 state_q;
  logic [PW-1:0]          per_q, per_d;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, overrun_q, cs_q, busy_q;
  logic                   trigger, ovr_set;
  logic                   div_run, div_tick, sclk_rise, sclk_fall;

  // Period counter: free-runs while enabled, parked at 0 otherwise.
  assign trigger = enable && (per_q == PW'(SAMPLE_PERIOD - 1));

  always_comb begin
    per_d = per_q + 1'b1;
    if (!enable || trigger) begin
      per_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

  // FINISH keeps the divider counting so it times the tail, but sclk stays low.
  assign div_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_FINISH);

  spi_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .run_i      (div_run),
    .hold_low_i (state_q == ST_FINISH),
    .sclk_o     (sclk),
    .tick_o     (div_tick),
    .rise_o     (sclk_rise),
    .fall_o     (sclk_fall)
  );

  assign ovr_set = (trigger && (state_q != ST_IDLE)) ||
                   ((state_q == ST_PUBLISH) && valid_q && !sample_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end

      if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q   <= ST_SETUP;
            cs_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        end
        ST_SETUP: begin
          if (sclk_rise) begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The falling edge after the last rising edge is the FINISH entry.
          if (sclk_fall && (bit_cnt_q == BW'(FRAME_BITS))) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (div_tick) begin
            state_q <= ST_PUBLISH;
            cs_q    <= 1'b1;
          end
        end
        ST_PUBLISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          // Loading here overrides the handshake clear above.
          if (!valid_q || sample_ready) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cs_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase

      // The first rising edge is launched from SETUP, so capture by strobe.
      if (sclk_rise) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (bit_cnt_q < BW'(DATA_BITS)) begin
          shift_q <= {shift_q[DATA_BITS-2:0], miso};
        end
      end
    end
  end

  assign cs           = cs_q;
  assign busy         = busy_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_capture_ctrl.sv
// Directed bench for spi_capture_ctrl at default parameters. A converter
// model presents the sample MSB first (then zeros) and a monitor records
// frame timing, sclk rising-edge counts and valid pulses.
module tb_spi_capture_ctrl;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned FRAME_BITS    = 34;
  localparam int unsigned DATA_BITS     = 16;
  localparam int unsigned SAMPLE_PERIOD = 1024;
  // cs-falling cycle through cs-rising cycle, both counted.
  localparam int unsigned EXP_LEN       = CLK_DIV * (2 * FRAME_BITS + 1) + 1;

  logic                 clk = 1'b0;
  logic                 reset, enable, miso, sample_ready, clr_overrun;
  logic                 sclk, cs, sample_valid, overrun, busy;
  logic [DATA_BITS-1:0] sample_data;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [15:0] cur_data = 16'h0000;
  int unsigned cyc = 0, rises = 0, frames_done = 0, frames_started = 0;
  int unsigned fall_cyc = 0, last_len = 0, last_rises = 0, last_period = 0, valid_cnt = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int unsigned en_edge;

  spi_capture_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .FRAME_BITS    (FRAME_BITS),
    .DATA_BITS     (DATA_BITS),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .miso         (miso),
    .sclk         (sclk),
    .cs           (cs),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .clr_overrun  (clr_overrun),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Monitor + converter model, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (prev_cs && !cs) begin
      frames_started++;
      last_period = cyc - fall_cyc;
      fall_cyc    = cyc;
      rises       = 0;
      valid_cnt   = 0;
    end
    if (!prev_sclk && sclk) rises++;
    if (!prev_cs && cs) begin
      last_len   = cyc - fall_cyc + 1;
      last_rises = rises;
      frames_done++;
    end
    if (sample_valid) valid_cnt++;
    miso = (rises < 16) ? cur_data[4'(15 - rises)] : 1'b0;
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  task automatic wait_frames(input int unsigned n, input int unsigned budget);
    int unsigned target;
    bit ok;
    target = frames_done + n;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_frames timeout got=%0d exp=%0d", frames_done, target);
    end
  endtask

  task automatic wait_rises(input int unsigned n, input int unsigned budget);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cs && rises == n) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_rises timeout got=%0d exp=%0d", rises, n);
    end
  endtask

  task automatic consume();
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sample_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL rst_cs got=%b exp=1", cs); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
    checks++; if (sample_data !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", sample_data); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cur_data = 16'hA5C3;
    @(negedge clk);
    enable  = 1'b1;
    en_edge = cyc + 1;
    wait_frames(1, 3000);
    repeat (3) @(negedge clk);
    // cs falls on the SAMPLE_PERIOD-th edge, counting the first enabled edge as 1.
    checks++; if (fall_cyc - en_edge !== SAMPLE_PERIOD - 1) begin failures++; $display("FAIL basic_first_trigger got=%0d exp=%0d", fall_cyc - en_edge, SAMPLE_PERIOD - 1); end
    checks++; if (sample_data !== 16'hA5C3) begin failures++; $display("FAIL basic_data got=%h exp=a5c3", sample_data); end
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", sample_valid); end
    checks++; if (last_rises !== FRAME_BITS) begin failures++; $display("FAIL basic_rises got=%0d exp=%0d", last_rises, FRAME_BITS); end
    checks++; if (last_len !== EXP_LEN) begin failures++; $display("FAIL basic_frame_len got=%0d exp=%0d", last_len, EXP_LEN); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    consume();
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL basic_consume got=%b exp=0", sample_valid); end
  endtask

  task automatic test_overrun();
    cur_data = 16'h1234;
    wait_frames(1, 1500);
    repeat (3) @(negedge clk);
    checks++; if (sample_data !== 16'h1234) begin failures++; $display("FAIL ovr_first_data got=%h exp=1234", sample_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_first_flag got=%b exp=0", overrun); end
    cur_data = 16'h5678;
    wait_frames(1, 1500);
    repeat (3) @(negedge clk);
    checks++; if (sample_data !== 16'h1234) begin failures++; $display("FAIL ovr_kept_data got=%h exp=1234", sample_data); end
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", sample_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    consume();
  endtask

  task automatic test_stream();
    sample_ready = 1'b1;
    cur_data = 16'h0F0F;
    wait_frames(1, 1500);
    repeat (3) @(negedge clk);
    checks++; if (sample_data !== 16'h0F0F) begin failures++; $display("FAIL stream_data0 got=%h exp=0f0f", sample_data); end
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL stream_pulse0 got=%0d exp=1", valid_cnt); end
    cur_data = 16'hF00F;
    wait_frames(1, 1500);
    repeat (3) @(negedge clk);
    checks++; if (sample_data !== 16'hF00F) begin failures++; $display("FAIL stream_data1 got=%h exp=f00f", sample_data); end
    checks++; if (valid_cnt !== 1) begin failures++; $display("FAIL stream_pulse1 got=%0d exp=1", valid_cnt); end
    checks++; if (last_period !== SAMPLE_PERIOD) begin failures++; $display("FAIL stream_period got=%0d exp=%0d", last_period, SAMPLE_PERIOD); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL stream_valid got=%b exp=0", sample_valid); end
    sample_ready = 1'b0;
  endtask

  task automatic test_ready_on_publish();
    cur_data = 16'h1111;
    wait_frames(1, 1500);
    cur_data = 16'h2222;
    wait_frames(1, 1500);
    // Now inside the PUBLISH cycle: cs already high, sequencer still busy.
    checks++; if ({cs, busy, sample_valid} !== 3'b111) begin failures++; $display("FAIL pub_state got=%b exp=111", {cs, busy, sample_valid}); end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    checks++; if (sample_data !== 16'h2222) begin failures++; $display("FAIL pub_data got=%h exp=2222", sample_data); end
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL pub_valid got=%b exp=1", sample_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL pub_overrun got=%b exp=0", overrun); end
    consume();
  endtask

  task automatic test_reset_midframe();
    cur_data = 16'hBEEF;
    wait_rises(10, 1500);
    reset = 1'b1;
    #1;
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL midrst_cs got=%b exp=1", cs); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk got=%b exp=0", sclk); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", sample_valid); end
    checks++; if (sample_data !== 16'h0000) begin failures++; $display("FAIL midrst_data got=%h exp=0000", sample_data); end
    cur_data = 16'h3C5A;
    wait_frames(1, 3000);
    repeat (3) @(negedge clk);
    checks++; if (sample_data !== 16'h3C5A) begin failures++; $display("FAIL midrst_next_data got=%h exp=3c5a", sample_data); end
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL midrst_next_valid got=%b exp=1", sample_valid); end
    checks++; if (last_rises !== FRAME_BITS) begin failures++; $display("FAIL midrst_next_rises got=%0d exp=%0d", last_rises, FRAME_BITS); end
    checks++; if (last_len !== EXP_LEN) begin failures++; $display("FAIL midrst_next_len got=%0d exp=%0d", last_len, EXP_LEN); end
    consume();
  endtask

  task automatic test_enable_drop();
    int unsigned started;
    cur_data = 16'h6D2B;
    wait_rises(20, 1500);
    enable = 1'b0;
    wait_frames(1, 1500);
    repeat (3) @(negedge clk);
    checks++; if (sample_data !== 16'h6D2B) begin failures++; $display("FAIL endrop_data got=%h exp=6d2b", sample_data); end
    checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL endrop_valid got=%b exp=1", sample_valid); end
    checks++; if (last_rises !== FRAME_BITS) begin failures++; $display("FAIL endrop_rises got=%0d exp=%0d", last_rises, FRAME_BITS); end
    started = frames_started;
    repeat (2500) @(negedge clk);
    checks++; if (frames_started !== started) begin failures++; $display("FAIL endrop_quiet got=%0d exp=%0d", frames_started, started); end
    checks++; if ({cs, sclk, busy} !== 3'b100) begin failures++; $display("FAIL endrop_idle got=%b exp=100", {cs, sclk, busy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_stream();
    test_ready_on_publish();
    test_reset_midframe();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
